// File: rtl/flash_seq_arb.sv
// flash_seq_arb: single-word access sequencer for an asynchronous parallel NOR
// flash, with round-robin arbitration between two requesters (m0 = JTAG
// flasher, m1 = local/boot reader). Every access walks
// IDLE -> SETUP -> ACTIVE -> HOLD -> TURN -> IDLE. All pin-facing outputs are
// registered. The flash_d tristate buffer lives one level up.
module flash_seq_arb #(
  parameter int adr_width  = 24,
  parameter int rd_wait    = 6,
  parameter int wr_wait    = 6,
  parameter int turnaround = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,

  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [adr_width-1:0] m0_adr,
  input  logic [15:0]          m0_dat_w,
  output logic [15:0]          m0_dat_r,
  output logic                 m0_ack,

  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [adr_width-1:0] m1_adr,
  input  logic [15:0]          m1_dat_w,
  output logic [15:0]          m1_dat_r,
  output logic                 m1_ack,

  output logic [adr_width-1:0] flash_adr,
  output logic [15:0]          flash_d_o,
  output logic                 flash_d_oe,
  input  logic [15:0]          flash_d_i,
  output logic                 flash_oe_n,
  output logic                 flash_we_n,
  input  logic                 flash_sts,
  output logic                 sts_ready,
  output logic                 busy
);

  // Strobe widths are clamped to 1..15 so a zero parameter still gives a
  // one-cycle strobe; the down-counter is loaded with width-1.
  localparam int RD_EFF = (rd_wait < 1) ? 1 : ((rd_wait > 15) ? 15 : rd_wait);
  localparam int WR_EFF = (wr_wait < 1) ? 1 : ((wr_wait > 15) ? 15 : wr_wait);
  localparam logic [3:0] RD_LOAD = 4'(RD_EFF - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_EFF - 1);

  // Turnaround is clamped to 0..7; zero removes the TURN state entirely.
  localparam int TA_EFF = (turnaround < 0) ? 0 : ((turnaround > 7) ? 7 : turnaround);
  localparam logic [2:0] TA_LOAD = 3'((TA_EFF > 0) ? (TA_EFF - 1) : 0);
  localparam bit TA_SKIP = (TA_EFF == 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_TURN
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [2:0]             r_tcnt;
  logic                   r_gnt;
  logic                   r_last;
  logic                   r_we;
  logic [adr_width-1:0]   r_flash_adr;
  logic [15:0]            r_flash_d_o;
  logic                   r_flash_d_oe;
  logic                   r_flash_oe_n;
  logic                   r_flash_we_n;
  logic                   r_m0_ack;
  logic                   r_m1_ack;
  logic [15:0]            r_m0_dat_r;
  logic [15:0]            r_m1_dat_r;
  logic                   r_busy;
  logic                   r_sts_meta;
  logic                   r_sts_sync;

  logic                   w_any;
  logic                   w_sel;
  logic                   w_sel_we;
  logic [adr_width-1:0]   w_sel_adr;
  logic [15:0]            w_sel_dat;

  // Arbitration: on a tie the requester that was not granted last time wins.
  always_comb begin
    w_any     = m0_stb | m1_stb;
    w_sel     = (m0_stb & m1_stb) ? ~r_last : m1_stb;
    w_sel_we  = w_sel ? m1_we    : m0_we;
    w_sel_adr = w_sel ? m1_adr   : m0_adr;
    w_sel_dat = w_sel ? m1_dat_w : m0_dat_w;
  end

  // Access sequencer; every pin and handshake output is a register set here.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_tcnt       <= 3'd0;
      r_gnt        <= 1'b0;
      r_last       <= 1'b1;
      r_we         <= 1'b0;
      r_flash_adr  <= '0;
      r_flash_d_o  <= 16'd0;
      r_flash_d_oe <= 1'b0;
      r_flash_oe_n <= 1'b1;
      r_flash_we_n <= 1'b1;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_dat_r   <= 16'd0;
      r_m1_dat_r   <= 16'd0;
      r_busy       <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_SETUP;
            r_gnt       <= w_sel;
            r_last      <= w_sel;
            r_we        <= w_sel_we;
            r_flash_adr <= w_sel_adr;
            r_busy      <= 1'b1;
            if (w_sel_we) begin
              r_flash_d_oe <= 1'b1;
              r_flash_d_o  <= w_sel_dat;
            end
          end
        end
        ST_SETUP: begin
          r_state      <= ST_ACTIVE;
          r_cnt        <= r_we ? WR_LOAD : RD_LOAD;
          r_flash_oe_n <= r_we;
          r_flash_we_n <= ~r_we;
        end
        ST_ACTIVE: begin
          if (r_cnt == 4'd0) begin
            r_state      <= ST_HOLD;
            r_flash_oe_n <= 1'b1;
            r_flash_we_n <= 1'b1;
            if (r_gnt) begin
              r_m1_ack <= 1'b1;
            end else begin
              r_m0_ack <= 1'b1;
            end
            if (!r_we) begin
              if (r_gnt) begin
                r_m1_dat_r <= flash_d_i;
              end else begin
                r_m0_dat_r <= flash_d_i;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          r_flash_d_oe <= 1'b0;
          if (TA_SKIP) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_TURN;
            r_tcnt  <= TA_LOAD;
          end
        end
        ST_TURN: begin
          if (r_tcnt == 3'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt - 3'd1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_flash_oe_n <= 1'b1;
          r_flash_we_n <= 1'b1;
          r_flash_d_oe <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous ready/busy pin.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sts_meta <= 1'b0;
      r_sts_sync <= 1'b0;
    end else begin
      r_sts_meta <= flash_sts;
      r_sts_sync <= r_sts_meta;
    end
  end

  assign flash_adr  = r_flash_adr;
  assign flash_d_o  = r_flash_d_o;
  assign flash_d_oe = r_flash_d_oe;
  assign flash_oe_n = r_flash_oe_n;
  assign flash_we_n = r_flash_we_n;
  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_dat_r   = r_m0_dat_r;
  assign m1_dat_r   = r_m1_dat_r;
  assign busy       = r_busy;
  assign sts_ready  = r_sts_sync;

endmodule

// File: tb/tb_flash_seq_arb.sv
// Testbench for flash_seq_arb: two instances (default timing, and a fast
// variant with rd_wait=0, wr_wait=3, turnaround=0) driven by directed and
// random requests, compared cycle by cycle against a timeline model that
// derives every pin from the offset since the grant edge.
module tb_flash_seq_arb;

  typedef struct packed {
    logic        m0Stb;
    logic        m0We;
    logic [23:0] m0Adr;
    logic [15:0] m0DatW;
    logic        m1Stb;
    logic        m1We;
    logic [23:0] m1Adr;
    logic [15:0] m1DatW;
    logic [15:0] flashDI;
    logic        flashSts;
  } ins_t;

  typedef struct packed {
    logic [15:0] m0DatR;
    logic        m0Ack;
    logic [15:0] m1DatR;
    logic        m1Ack;
    logic [23:0] flashAdr;
    logic [15:0] flashDO;
    logic        flashDOe;
    logic        flashOeN;
    logic        flashWeN;
    logic        stsReady;
    logic        busy;
  } outs_t;

  logic  clk;
  logic  rstN;
  ins_t  inV [2];
  outs_t outA;
  outs_t outB;

  int vectors;
  int miscompares;

  int rdEff [2] = '{6, 1};
  int wrEff [2] = '{6, 3};
  int taEff [2] = '{2, 0};

  int          edgeNo;
  int          nextGrant [2];
  int          startEdge [2];
  int          curW      [2];
  int          curM      [2];
  int          lastG     [2];
  bit          hasTxn    [2];
  bit          curWe     [2];
  logic [23:0] expAdr    [2];
  logic [15:0] expDO     [2];
  logic [15:0] expDatR0  [2];
  logic [15:0] expDatR1  [2];
  logic        prevSts   [2];
  int          modelAcks [2];
  int          seenAcks  [2];

  flash_seq_arb #(.adr_width(24), .rd_wait(6), .wr_wait(6), .turnaround(2)) dutA (
    .sys_clk   (clk),
    .sys_rst_n (rstN),
    .m0_stb    (inV[0].m0Stb),
    .m0_we     (inV[0].m0We),
    .m0_adr    (inV[0].m0Adr),
    .m0_dat_w  (inV[0].m0DatW),
    .m0_dat_r  (outA.m0DatR),
    .m0_ack    (outA.m0Ack),
    .m1_stb    (inV[0].m1Stb),
    .m1_we     (inV[0].m1We),
    .m1_adr    (inV[0].m1Adr),
    .m1_dat_w  (inV[0].m1DatW),
    .m1_dat_r  (outA.m1DatR),
    .m1_ack    (outA.m1Ack),
    .flash_adr (outA.flashAdr),
    .flash_d_o (outA.flashDO),
    .flash_d_oe(outA.flashDOe),
    .flash_d_i (inV[0].flashDI),
    .flash_oe_n(outA.flashOeN),
    .flash_we_n(outA.flashWeN),
    .flash_sts (inV[0].flashSts),
    .sts_ready (outA.stsReady),
    .busy      (outA.busy)
  );

  flash_seq_arb #(.adr_width(24), .rd_wait(0), .wr_wait(3), .turnaround(0)) dutB (
    .sys_clk   (clk),
    .sys_rst_n (rstN),
    .m0_stb    (inV[1].m0Stb),
    .m0_we     (inV[1].m0We),
    .m0_adr    (inV[1].m0Adr),
    .m0_dat_w  (inV[1].m0DatW),
    .m0_dat_r  (outB.m0DatR),
    .m0_ack    (outB.m0Ack),
    .m1_stb    (inV[1].m1Stb),
    .m1_we     (inV[1].m1We),
    .m1_adr    (inV[1].m1Adr),
    .m1_dat_w  (inV[1].m1DatW),
    .m1_dat_r  (outB.m1DatR),
    .m1_ack    (outB.m1Ack),
    .flash_adr (outB.flashAdr),
    .flash_d_o (outB.flashDO),
    .flash_d_oe(outB.flashDOe),
    .flash_d_i (inV[1].flashDI),
    .flash_oe_n(outB.flashOeN),
    .flash_we_n(outB.flashWeN),
    .flash_sts (inV[1].flashSts),
    .sts_ready (outB.stsReady),
    .busy      (outB.busy)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t getOut(input int i);
    return (i == 0) ? outA : outB;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    edgeNo = 0;
    for (int i = 0; i < 2; i++) begin
      nextGrant[i] = 0;
      hasTxn[i]    = 1'b0;
      lastG[i]     = 1;
      expAdr[i]    = '0;
      expDO[i]     = '0;
      expDatR0[i]  = '0;
      expDatR1[i]  = '0;
      prevSts[i]   = 1'b0;
    end
  endtask

  task automatic checkResetValues(input string phase);
    outs_t o;
    for (int i = 0; i < 2; i++) begin
      o = getOut(i);
      checkOutput($sformatf("%s.i%0d.m0Ack", phase, i), 32'(o.m0Ack), 32'd0);
      checkOutput($sformatf("%s.i%0d.m1Ack", phase, i), 32'(o.m1Ack), 32'd0);
      checkOutput($sformatf("%s.i%0d.oeN", phase, i), 32'(o.flashOeN), 32'd1);
      checkOutput($sformatf("%s.i%0d.weN", phase, i), 32'(o.flashWeN), 32'd1);
      checkOutput($sformatf("%s.i%0d.dOe", phase, i), 32'(o.flashDOe), 32'd0);
      checkOutput($sformatf("%s.i%0d.adr", phase, i), 32'(o.flashAdr), 32'd0);
      checkOutput($sformatf("%s.i%0d.dO", phase, i), 32'(o.flashDO), 32'd0);
      checkOutput($sformatf("%s.i%0d.datR0", phase, i), 32'(o.m0DatR), 32'd0);
      checkOutput($sformatf("%s.i%0d.datR1", phase, i), 32'(o.m1DatR), 32'd0);
      checkOutput($sformatf("%s.i%0d.busy", phase, i), 32'(o.busy), 32'd0);
      checkOutput($sformatf("%s.i%0d.sts", phase, i), 32'(o.stsReady), 32'd0);
    end
  endtask

  // Reference timeline: an access granted at edge k occupies offsets
  // d = 0 (setup), 1..W (strobe low), W+1 (hold/ack), W+2..W+1+T (turn),
  // and the next grant may happen at edge k+3+W+T.
  task automatic modelStep(input int i);
    ins_t  s;
    outs_t o;
    int    d;
    bit    inTxn;
    bit    ackNow;
    logic  expOeN;
    logic  expWeN;
    logic  expDOe;
    logic  expSts;
    s = inV[i];
    o = getOut(i);

    expSts     = prevSts[i];
    prevSts[i] = s.flashSts;

    if (edgeNo >= nextGrant[i] && (s.m0Stb || s.m1Stb)) begin
      curM[i]      = (s.m0Stb && s.m1Stb) ? (1 - lastG[i]) : (s.m1Stb ? 1 : 0);
      lastG[i]     = curM[i];
      curWe[i]     = (curM[i] == 1) ? s.m1We : s.m0We;
      curW[i]      = curWe[i] ? wrEff[i] : rdEff[i];
      startEdge[i] = edgeNo;
      hasTxn[i]    = 1'b1;
      nextGrant[i] = edgeNo + 3 + curW[i] + taEff[i];
      expAdr[i]    = (curM[i] == 1) ? s.m1Adr : s.m0Adr;
      if (curWe[i]) expDO[i] = (curM[i] == 1) ? s.m1DatW : s.m0DatW;
    end

    d      = edgeNo - startEdge[i];
    inTxn  = hasTxn[i] && (d <= curW[i] + 1 + taEff[i]);
    ackNow = inTxn && (d == curW[i] + 1);
    expOeN = !(inTxn && !curWe[i] && d >= 1 && d <= curW[i]);
    expWeN = !(inTxn && curWe[i] && d >= 1 && d <= curW[i]);
    expDOe = inTxn && curWe[i] && (d <= curW[i] + 1);
    if (ackNow) begin
      modelAcks[i]++;
      if (!curWe[i]) begin
        if (curM[i] == 1) expDatR1[i] = s.flashDI;
        else expDatR0[i] = s.flashDI;
      end
    end
    if (!inTxn) hasTxn[i] = 1'b0;
    if (o.m0Ack || o.m1Ack) seenAcks[i]++;

    checkOutput($sformatf("i%0d.oeN", i), 32'(o.flashOeN), 32'(expOeN));
    checkOutput($sformatf("i%0d.weN", i), 32'(o.flashWeN), 32'(expWeN));
    checkOutput($sformatf("i%0d.dOe", i), 32'(o.flashDOe), 32'(expDOe));
    checkOutput($sformatf("i%0d.adr", i), 32'(o.flashAdr), 32'(expAdr[i]));
    if (expDOe) checkOutput($sformatf("i%0d.dO", i), 32'(o.flashDO), 32'(expDO[i]));
    checkOutput($sformatf("i%0d.m0Ack", i), 32'(o.m0Ack), 32'(ackNow && curM[i] == 0));
    checkOutput($sformatf("i%0d.m1Ack", i), 32'(o.m1Ack), 32'(ackNow && curM[i] == 1));
    checkOutput($sformatf("i%0d.datR0", i), 32'(o.m0DatR), 32'(expDatR0[i]));
    checkOutput($sformatf("i%0d.datR1", i), 32'(o.m1DatR), 32'(expDatR1[i]));
    checkOutput($sformatf("i%0d.busy", i), 32'(o.busy), 32'(inTxn));
    checkOutput($sformatf("i%0d.sts", i), 32'(o.stsReady), 32'(expSts));
    checkOutput($sformatf("i%0d.oeWithDrive", i), 32'(!o.flashOeN && o.flashDOe), 32'd0);
  endtask

  // Modes: 0 idle, 1 m0 read of 0x000123, 2 m1 write 0x7FFFFF/0x00A5,
  // 3 both requesters held high, 4 fully random, 5 m0 write only.
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < 2; i++) begin
      inV[i].flashDI = 16'($urandom);
      if ($urandom_range(7) == 0) inV[i].flashSts = ~inV[i].flashSts;
      inV[i].m0Adr  = 24'($urandom);
      inV[i].m1Adr  = 24'($urandom);
      inV[i].m0DatW = 16'($urandom);
      inV[i].m1DatW = 16'($urandom);
      inV[i].m0We   = 1'($urandom);
      inV[i].m1We   = 1'($urandom);
      case (mode)
        0: begin
          inV[i].m0Stb = 1'b0;
          inV[i].m1Stb = 1'b0;
        end
        1: begin
          inV[i].m0Stb   = 1'b1;
          inV[i].m0We    = 1'b0;
          inV[i].m0Adr   = 24'h000123;
          inV[i].flashDI = 16'hBEEF;
          inV[i].m1Stb   = 1'b0;
        end
        2: begin
          inV[i].m1Stb  = 1'b1;
          inV[i].m1We   = 1'b1;
          inV[i].m1Adr  = 24'h7FFFFF;
          inV[i].m1DatW = 16'h00A5;
          inV[i].m0Stb  = 1'b0;
        end
        3: begin
          inV[i].m0Stb = 1'b1;
          inV[i].m1Stb = 1'b1;
        end
        5: begin
          inV[i].m0Stb = 1'b1;
          inV[i].m0We  = 1'b1;
          inV[i].m1Stb = 1'b0;
        end
        default: begin
          inV[i].m0Stb = ($urandom_range(3) != 0);
          inV[i].m1Stb = ($urandom_range(3) != 0);
        end
      endcase
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic runCycles(input int n, input int mode);
    repeat (n) begin
      applyStimulus(mode);
      @(posedge clk);
      #1;
      if (rstN) begin
        edgeNo++;
        for (int i = 0; i < 2; i++) modelStep(i);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 2; i++) begin
      inV[i]       = '0;
      modelAcks[i] = 0;
      seenAcks[i]  = 0;
    end
    rstN = 1'b0;
    modelReset();
    #22;
    checkResetValues("por");

    @(negedge clk);
    rstN = 1'b1;
    runCycles(20, 1);
    runCycles(14, 0);
    runCycles(20, 2);
    runCycles(14, 0);
    runCycles(50, 3);
    runCycles(14, 0);

    runCycles(4, 5);
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues("midWrite");
    modelReset();
    applyStimulus(3);
    @(negedge clk);
    @(negedge clk);
    checkResetValues("heldReset");
    rstN = 1'b1;
    runCycles(40, 3);

    runCycles(1500, 4);
    runCycles(14, 0);

    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("i%0d.ackCount", i), 32'(seenAcks[i]), 32'(modelAcks[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
